// File: rtl/vga_timing_detector.sv
// Receive-side VGA timing detector: measures line/frame format from hsync/vsync/data_enable,
// locks once stable and emits per-pixel coordinates. Define POLARITY_AUTO_EN for sync polarity detection.
module vga_timing_detector #(
  parameter int HW          = 12,
  parameter int VW          = 11,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          data_enable,
  output logic          active,
  output logic [HW-1:0] pixel_x,
  output logic [VW-1:0] pixel_y,
  output logic          frame_start,
  output logic [HW-1:0] h_total,
  output logic [HW-1:0] h_active,
  output logic [VW-1:0] v_total,
  output logic [VW-1:0] v_active,
  output logic          locked,
  output logic          timing_error
);
  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [1:0] SEARCH  = 2'd0;
  localparam logic [1:0] MEASURE = 2'd1;
  localparam logic [1:0] VERIFY  = 2'd2;
  localparam logic [1:0] LOCKED  = 2'd3;
  localparam logic [HW-1:0] HMAX = '1;
  localparam logic [VW-1:0] VMAX = '1;

  typedef struct packed {
    logic [HW-1:0] ht;
    logic [HW-1:0] ha;
    logic [VW-1:0] vt;
    logic [VW-1:0] va;
  } rec_t;

  // Two-stage input pipe, bits {de, vs, hs}; syncs reset low so no false falling edge after reset
  logic [1:0][2:0] sync_pipe;
  logic [2:0]      s1, s2;
  assign s1 = sync_pipe[0];
  assign s2 = sync_pipe[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_pipe <= {2{3'b100}};
    else        sync_pipe <= {sync_pipe[0], {data_enable, vsync, hsync}};
  end

  logic line_edge, frame_edge, pol_chg, vis;
  assign vis = ~s2[2];

`ifdef POLARITY_AUTO_EN
  // hpol/vpol = 1 means active-high; learned from the idle sync level at each visible-run start
  logic hpol, vpol, de_fall;
  assign de_fall = s2[2] & ~s1[2];
  assign pol_chg = de_fall & ((~s1[0] != hpol) | (~s1[1] != vpol));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hpol <= 1'b0;
      vpol <= 1'b0;
    end else if (de_fall) begin
      hpol <= ~s1[0];
      vpol <= ~s1[1];
    end
  end

  assign line_edge  = (s2[0] ^ hpol) & ~(s1[0] ^ hpol);
  assign frame_edge = (s2[1] ^ vpol) & ~(s1[1] ^ vpol);
`else
  assign pol_chg    = 1'b0;
  assign line_edge  = s2[0] & ~s1[0];
  assign frame_edge = s2[1] & ~s1[1];
`endif

  // Per-line and per-frame measurement state
  logic [HW-1:0] hcnt, acnt, fper, fwid;
  logic [VW-1:0] vcnt, vacnt;
  logic          hper, hwid, bad;
  logic [HW-1:0] hcnt_n, acnt_n, fper_n, fwid_n, per;
  logic [VW-1:0] vcnt_n, vacnt_n, pixy_n;
  logic          hper_n, hwid_n, bad_n, h_sat;

  always_comb begin
    h_sat   = (hcnt == HMAX);
    per     = h_sat ? HMAX : hcnt + 1'b1;
    hcnt_n  = line_edge ? '0 : per;
    acnt_n  = line_edge ? '0 : ((vis && acnt != HMAX) ? acnt + 1'b1 : acnt);
    // A frame edge starts from a clean record; a coinciding line edge lands in the new frame
    vcnt_n  = frame_edge ? '0 : vcnt;
    vacnt_n = frame_edge ? '0 : vacnt;
    pixy_n  = frame_edge ? '0 : pixel_y;
    fper_n  = frame_edge ? '0 : fper;
    fwid_n  = frame_edge ? '0 : fwid;
    hper_n  = frame_edge ? 1'b0 : hper;
    hwid_n  = frame_edge ? 1'b0 : hwid;
    bad_n   = (frame_edge ? 1'b0 : bad) | h_sat | (vis & (acnt == HMAX));
    if (line_edge) begin
      if (vcnt_n == VMAX) bad_n = 1'b1;
      else                vcnt_n = vcnt_n + 1'b1;
      if (acnt != '0) begin
        if (vacnt_n == VMAX) bad_n = 1'b1;
        else                 vacnt_n = vacnt_n + 1'b1;
        if (pixy_n != VMAX) pixy_n = pixy_n + 1'b1;
        if (!hwid_n) begin
          fwid_n = acnt;
          hwid_n = 1'b1;
        end else if (acnt != fwid_n) begin
          bad_n = 1'b1;
        end
      end
      if (!hper_n) begin
        fper_n = per;
        hper_n = 1'b1;
      end else if (per != fper_n) begin
        bad_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt <= '0; acnt <= '0; vcnt <= '0; vacnt <= '0;
      fper <= '0; fwid <= '0; hper <= 1'b0; hwid <= 1'b0; bad <= 1'b0;
      pixel_y <= '0; pixel_x <= '0; active <= 1'b0; frame_start <= 1'b0;
    end else begin
      hcnt <= hcnt_n; acnt <= acnt_n; vcnt <= vcnt_n; vacnt <= vacnt_n;
      fper <= fper_n; fwid <= fwid_n; hper <= hper_n; hwid <= hwid_n; bad <= bad_n;
      pixel_y     <= pixy_n;
      active      <= ~s1[2];
      frame_start <= frame_edge;
      if (!s1[2]) pixel_x <= !active ? '0 : ((pixel_x == HMAX) ? HMAX : pixel_x + 1'b1);
    end
  end

  // Lock state machine, advanced only at frame edges
  rec_t          rec, ref_rec;
  logic          rec_good;
  logic [1:0]    state;
  logic [MW-1:0] match, match_inc;

  assign rec       = '{ht: fper, ha: fwid, vt: vcnt, va: vacnt};
  assign rec_good  = ~bad & hper;
  assign match_inc = match + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEARCH; match <= '0; ref_rec <= '0;
      locked <= 1'b0; timing_error <= 1'b0;
      h_total <= '0; h_active <= '0; v_total <= '0; v_active <= '0;
    end else begin
      timing_error <= 1'b0;
      if (frame_edge) begin
        case (state)
          SEARCH: begin
            state   <= MEASURE;
            ref_rec <= '0;
            match   <= '0;
          end
          MEASURE: begin
            ref_rec <= rec;
            match   <= rec_good ? MW'(1) : '0;
            state   <= VERIFY;
          end
          VERIFY: begin
            if (rec_good && rec == ref_rec) begin
              if (match_inc >= MW'(LOCK_FRAMES)) begin
                state    <= LOCKED;
                locked   <= 1'b1;
                h_total  <= ref_rec.ht;
                h_active <= ref_rec.ha;
                v_total  <= ref_rec.vt;
                v_active <= ref_rec.va;
              end else begin
                match <= match_inc;
              end
            end else begin
              ref_rec <= rec;
              match   <= rec_good ? MW'(1) : '0;
            end
          end
          default: begin
            if (!(rec_good && rec == ref_rec)) begin
              state        <= VERIFY;
              locked       <= 1'b0;
              timing_error <= 1'b1;
              ref_rec      <= rec;
              match        <= '0;
            end
          end
        endcase
      end else if (pol_chg && state == LOCKED) begin
        state        <= VERIFY;
        locked       <= 1'b0;
        timing_error <= 1'b1;
        match        <= '0;
      end
    end
  end
endmodule

// File: doc/vga_timing_detector.md
Name: vga_timing_detector

Overview:
Receive-side counterpart of the sync_signals VGA timing generator. It monitors an incoming hsync/vsync/data_enable stream on the pixel clock, measures the line and frame format, and locks once the format is stable. It then produces per-pixel x/y coordinates for downstream capture or overlay logic. It sits after the VGA input pins or after a sync_signals instance for loopback checking.

Parameters:
HW, 12, width of horizontal counters and measurements (clocks/pixels per line)
VW, 11, width of vertical counters and measurements (lines per frame)
LOCK_FRAMES, 2, consecutive matching frames required to assert locked

Ports:
clk  input  1  pixel clock (25 MHz from pixel_clock); all inputs synchronous to it
rst_n  input  1  asynchronous active-low reset
hsync  input  1  horizontal sync, active-low
vsync  input  1  vertical sync, active-low
data_enable  input  1  active-low: 0 = visible pixel (sync_signals polarity)
active  output  1  registered visible-pixel flag, active-high
pixel_x  output  HW  column of current visible pixel, 0-based
pixel_y  output  VW  row of current visible pixel, 0-based
frame_start  output  1  one-clock pulse on each detected frame boundary
h_total  output  HW  measured clocks per line
h_active  output  HW  measured visible pixels per line
v_total  output  VW  measured lines per frame
v_active  output  VW  measured visible lines per frame
locked  output  1  format stable for LOCK_FRAMES frames
timing_error  output  1  one-clock pulse when a locked format changes

Behaviour:
- Reset (async, rst_n=0): all outputs 0, all counters 0, state SEARCH. Applies mid-frame. Measurement restarts from the next vsync edge.
- Input stage: hsync, vsync and data_enable are registered twice (s1, s2). Edges are taken from s1 vs s2. Line edge = hsync s2=1, s1=0. Frame edge = vsync s2=1, s1=0.
- active = registered s1 of !data_enable. active, pixel_x and pixel_y appear exactly 2 clocks after the pin change.
- pixel_x: 0 on the first visible clock of a run; +1 per visible clock; holds when not visible. Saturates at all-ones.
- Per-line counters:
  - hcnt: clocks since the last line edge.
  - acnt: visible clocks in the line.
  - line_vis: set if acnt>0.
- At a line edge: the line period is hcnt+1 and the line width is acnt. hcnt and acnt clear. If line_vis is set, pixel_y increments and vacnt increments. vcnt increments on every line edge.
- At a frame edge: pixel_y, vcnt and vacnt clear, and frame_start pulses. The frame record {h_total, h_active, v_total, v_active} is formed from the last completed frame.
- Frame consistency: within a frame, every line period must equal the first line period. Every nonzero line width must equal the first nonzero width. Otherwise the frame is marked bad.
- Vertical counting: a line edge coinciding with a frame edge counts toward the new frame.
- All counters saturate, never wrap. Saturation marks the frame bad.
- State machine, evaluated at frame edges only:
  - SEARCH: go to MEASURE; clear records.
  - MEASURE: store the record as the reference; match=1 if the frame is good; go to VERIFY.
  - VERIFY: a good frame equal to the reference gives match+1. If match reaches LOCK_FRAMES, go to LOCKED and drive the outputs from the reference. Otherwise take the new frame as reference with match=1 (0 if bad).
  - LOCKED: a good, equal frame holds. Any difference or bad frame drops locked, pulses timing_error, and loads the new record as reference in VERIFY with match=0.
- Measurement outputs update only on entry to LOCKED and hold until the next lock. locked is 1 only in LOCKED.
- No frame edge: counters saturate and the state holds.

Optional Feature:
POLARITY_AUTO_EN
- Defined: sample s1 of hsync and vsync on every data_enable falling edge. The sampled levels are the inactive sync levels, so sync polarity = inverse of the sample. Edges are then taken as the transition into the detected active level. Polarity defaults to active-low from reset until the first visible pixel. A polarity change while LOCKED is treated as a format change: timing_error pulses and the state goes to VERIFY.
- Undefined: syncs are fixed active-low and no polarity logic is built.

Test Plan:
- 640x480 stream from sync_signals (800 clk/line, 525 lines), 3 frames → locked=1 at the 3rd frame edge; h_total=800, h_active=640, v_total=525, v_active=480; frame_start pulses once per frame.
- Small format (20 clk/line, 10 visible, 8 lines, 4 visible) → last visible pixel reads pixel_x=9, pixel_y=3, active rises 2 clk after data_enable falls.
- Locked, then switch to 21 clk/line → timing_error pulses 1 clk at the next frame edge; locked=0; relocks 2 frames later with h_total=21.
- Reset asserted mid-line of frame 2 → all outputs 0 immediately; after release, locked requires 3 full frame edges again.
- Only one line of one frame has 11 visible clocks → that frame is bad; no lock from it; lock after 2 subsequent clean frames.
- With POLARITY_AUTO_EN, inverted hsync/vsync small format → locks with the same measurements as the non-inverted case.
